// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_pkg
//  Brief    : Shared default sizing constants for the async_fifo block.
//  Revision : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ptr
//  Brief    : Wrap-bit-extended FIFO pointer; increments modulo 2^(address_size+1).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int address_size = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_en,
    output logic [address_size:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc_en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo
//  Brief    : Single-clock FIFO with registered read data and full/empty flags.
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int data_width   = DATA_WIDTH,
    parameter int fifo_depth   = FIFO_DEPTH,
    parameter int address_size = $clog2(fifo_depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    logic [data_width-1:0] mem [fifo_depth];
    logic [address_size:0] wr_ptr;
    logic [address_size:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Both requests are qualified by the flags as they stand before the edge,
    // so a write into an empty FIFO is never visible to a same-cycle read.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[address_size] != rd_ptr[address_size]) &&
                   (wr_ptr[address_size-1:0] == rd_ptr[address_size-1:0]);

    fifo_ptr #(
        .address_size (address_size)
    ) u_wr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (wr_accept),
        .ptr    (wr_ptr)
    );

    fifo_ptr #(
        .address_size (address_size)
    ) u_rd_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (rd_accept),
        .ptr    (rd_ptr)
    );

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[address_size-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= mem[rd_ptr[address_size-1:0]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo
//  Brief    : Self-checking bench for async_fifo against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int         pass_cnt;
    int         total_cnt;
    logic [7:0] model_q[$];
    logic [7:0] model_dout;

    async_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_state(input string tag);
        logic [4:0] occ;
        occ = dut.wr_ptr - dut.rd_ptr;
        check({tag, "_dout"},  32'(data_out), 32'(model_dout));
        check({tag, "_empty"}, 32'(empty),    32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),     32'(model_q.size() == DEPTH));
        check({tag, "_occ"},   32'(occ),      32'(model_q.size()));
    endtask

    // One clock: drive away from the edge, advance the model with the
    // pre-edge occupancy, then compare just after the edge.
    task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
        bit wr_ok;
        bit rd_ok;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        wr_ok = w && (model_q.size() < DEPTH);
        rd_ok = r && (model_q.size() > 0);
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        #1;
        check_state(tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_dout = 8'h00;
        check({tag, "_async_empty"}, 32'(empty),    32'd1);
        check({tag, "_async_full"},  32'(full),     32'd0);
        check({tag, "_async_dout"},  32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle({tag, "_post"}, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        model_dout = 8'h00;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        data_in    = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        check("rst_dout",  32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle("basic_w", 1'b1, 1'b0, 8'hAA);
        cycle("basic_w", 1'b1, 1'b0, 8'hBB);
        cycle("basic_w", 1'b1, 1'b0, 8'hCC);
        cycle("basic_r", 1'b0, 1'b1, 8'h00);
        check("basic_first", 32'(data_out), 32'hAA);
        cycle("basic_r", 1'b0, 1'b1, 8'h00);
        check("basic_second", 32'(data_out), 32'hBB);
        cycle("basic_r", 1'b0, 1'b1, 8'h00);
        check("basic_third", 32'(data_out), 32'hCC);
        check("basic_empty", 32'(empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 8'($urandom));
        check("fill_full", 32'(full), 32'd1);
        cycle("drop_ff", 1'b1, 1'b0, 8'hFF);
        check("drop_full", 32'(full), 32'd1);

        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
        check("drain_empty", 32'(empty), 32'd1);
        cycle("read_empty", 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 8; i++) cycle("preload", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) cycle("simul_mid", 1'b1, 1'b1, 8'(8'h40 + i));

        for (int i = 0; i < 8; i++) cycle("topup", 1'b1, 1'b0, 8'($urandom));
        check("topup_full", 32'(full), 32'd1);
        cycle("simul_full", 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < DEPTH - 1; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);
        check("drain2_empty", 32'(empty), 32'd1);
        cycle("simul_empty", 1'b1, 1'b1, 8'h99);
        cycle("simul_empty_rd", 1'b0, 1'b1, 8'h00);
        check("simul_empty_val", 32'(data_out), 32'h99);

        for (int i = 0; i < 300; i++) begin
            cycle("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                  8'($urandom));
        end

        while (model_q.size() > 5) cycle("trim", 1'b0, 1'b1, 8'h00);
        while (model_q.size() < 5) cycle("grow", 1'b1, 1'b0, 8'($urandom));
        pulse_reset("midrst");
        cycle("after_w", 1'b1, 1'b0, 8'h5A);
        cycle("after_r", 1'b0, 1'b1, 8'h00);
        check("after_val", 32'(data_out), 32'h5A);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
